// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and memory-side handshake bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for the shared single-port memory, data first
// Optional fetch starvation guard enabled by defining STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, RESP} state_t;

    state_t        state, state_nxt;
    logic          grant_d, grant_if, force_if;

    logic          mem_req_q, mem_req_nxt;
    logic          mem_we_q, mem_we_nxt;
    logic [AW-1:0] mem_addr_q, mem_addr_nxt;
    logic [DW-1:0] mem_wdata_q, mem_wdata_nxt;
    logic          if_ack_q, if_ack_nxt;
    logic [DW-1:0] if_rdata_q, if_rdata_nxt;
    logic          d_ack_q, d_ack_nxt;
    logic [DW-1:0] d_rdata_q, d_rdata_nxt;

    // Only meaningful while in IDLE; the busy states ignore requester inputs.
    assign grant_d  = bus.d_req && !force_if;
    assign grant_if = bus.if_req && !grant_d;

`ifdef STARVE_GUARD_EN
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_d && bus.if_req) begin
                starve_cnt <= starve_cnt + CW'(1);
            end else if (grant_if) begin
                starve_cnt <= '0;
            end
        end
    end

    assign force_if = bus.if_req && (starve_cnt == CW'(STARVE_MAX));
`else
    localparam int unused_starve_max = STARVE_MAX;
    assign force_if = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state       <= state_nxt;
            mem_req_q   <= mem_req_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            if_ack_q    <= if_ack_nxt;
            if_rdata_q  <= if_rdata_nxt;
            d_ack_q     <= d_ack_nxt;
            d_rdata_q   <= d_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = D_BUSY;
                end else if (grant_if) begin
                    state_nxt = IF_BUSY;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (bus.mem_ack) begin
                    state_nxt = RESP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-side registers only change on a grant, so they stay put across wait states.
    always_comb begin
        mem_req_nxt   = mem_req_q;
        mem_we_nxt    = mem_we_q;
        mem_addr_nxt  = mem_addr_q;
        mem_wdata_nxt = mem_wdata_q;
        if_ack_nxt    = 1'b0;
        if_rdata_nxt  = if_rdata_q;
        d_ack_nxt     = 1'b0;
        d_rdata_nxt   = d_rdata_q;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = bus.d_we;
                    mem_addr_nxt  = bus.d_addr;
                    mem_wdata_nxt = bus.d_wdata;
                end else if (grant_if) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = bus.if_addr;
                    mem_wdata_nxt = '0;
                end else begin
                    mem_req_nxt   = 1'b0;
                end
            end
            IF_BUSY: begin
                if (bus.mem_ack) begin
                    if_rdata_nxt = bus.mem_rdata;
                    if_ack_nxt   = 1'b1;
                    mem_req_nxt  = 1'b0;
                end
            end
            D_BUSY: begin
                if (bus.mem_ack) begin
                    d_rdata_nxt = bus.mem_rdata;
                    d_ack_nxt   = 1'b1;
                    mem_req_nxt = 1'b0;
                end
            end
            default: begin
                mem_req_nxt = 1'b0;
            end
        endcase
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule
